jtag_tap_param: RTL and testbench
=================================

// Module: jtag_tap_param
// PURPOSE
//   Parametrised IEEE 1149.1-style TAP: 16-state controller, IR of IR_WIDTH bits, and three data
//   registers selected by the IR: IDCODE, BYPASS and one USER register.
//   All DR/IR paths are true shift chains with TDI->TDO, so any width of IDCODE/USER chain works.
//   Sits between the chip JTAG pins and on-chip debug logic; USER DR is the debug mailbox.
// PARAMETERS
//   IR_WIDTH       4             instruction register width (>=2)
//   IDCODE_VALUE   32'h000FAF01  value captured into the 32-bit IDCODE DR
//   USER_DR_WIDTH  8             width of the USER data register (>=1)
//   INSTR_IDCODE   4'b1110       IR code selecting IDCODE; also the IR reset value
//   INSTR_USER     4'b1010       IR code selecting USER DR
//   INSTR_BYPASS   all ones      IR code selecting BYPASS; any undefined code also selects BYPASS
// PORTS
//   tck            in   1              TAP clock; all state changes on posedge
//   trst           in   1              synchronous, active-high reset
//   enable         in   1              1 = TAP advances; 0 = all registers hold
//   tms            in   1              test mode select
//   tdi            in   1              serial data in
//   tdo            out  1              serial data out
//   tdo_en         out  1              1 while in ShiftDr/ShiftIr
//   tap_state      out  4              current tap_state_t encoding (debug/formal)
//   ir_value       out  IR_WIDTH       currently active (updated) instruction
//   user_dr_in     in   USER_DR_WIDTH  value captured into USER chain at CaptureDr
//   user_dr_out    out  USER_DR_WIDTH  USER value latched at UpdateDr
//   user_dr_update out  1              one-cycle pulse on the cycle user_dr_out changes
// BEHAVIOUR
//   Reset (trst=1 at posedge, dominates enable): state=TestLogicReset, ir_value=INSTR_IDCODE,
//     all shift chains 0, user_dr_out=0, user_dr_update=0; so tdo=0 and tdo_en=0.
//   enable=0: state, chains, IR and outputs hold; user_dr_update forced 0.
//   FSM: standard 16-state TAP graph on tms. Entering TestLogicReset by tms also sets ir_value=INSTR_IDCODE.
//     Five consecutive tms=1 edges reach TestLogicReset from any state.
//     Out-of-range encodings go to TestLogicReset on the next edge.
//   Capture/shift/update rules. "The edge leaving X" means the posedge at which current state is X.
//     CaptureIr: on the edge leaving it, the IR chain loads {0..., 2'b01}.
//     CaptureDr: on the edge leaving it, the selected chain loads:
//       IDCODE_VALUE, 1'b0 (BYPASS), or user_dr_in.
//     ShiftIr/ShiftDr: every edge leaving the state (including the exit edge with tms=1)
//       shifts the chain right: chain <= {tdi, chain[W-1:1]}.
//     UpdateIr: on the edge leaving it, ir_value <= IR chain.
//     UpdateDr with ir_value==INSTR_USER: on the edge leaving it,
//       user_dr_out <= USER chain and user_dr_update=1 for exactly that cycle.
//     UpdateDr with IDCODE/BYPASS selected: no side effect.
//   tdo: combinational = bit0 of active chain (IR chain in ShiftIr, DR chain in ShiftDr),
//     else 0. Hence the first bit is visible the cycle after the CaptureX->ShiftX edge,
//     and bits come out LSB first.
//   DR selection uses ir_value only; the IR chain contents mid-scan do not affect DR routing.
//   Pause/Exit states: chains hold their contents, and ShiftX re-entry via Exit2 continues the same scan.
//   Reset mid-scan: chain contents discarded, ir_value back to INSTR_IDCODE.
// STRUCTURE
//   Package jtag_pkg:
//     - tap_state_t: 4-bit binary enum (TestLogicReset=0 .. UpdateIr=15, same order as the existing jtag block).
//     - Default instruction constants.
//   Sub-module jtag_tap_fsm(tck, trst, enable, tms -> state, next_state); this datapath decodes it.
//   Datapath in top: IR chain, IDCODE 32-bit chain, bypass flop, USER chain, tdo mux.
// TESTING
//   1 Reset: trst=1 one edge -> tap_state=0, ir_value=4'b1110, tdo=0, tdo_en=0, user_dr_out=0.
//   2 From ShiftDr, tms=1 x5 -> tap_state=TestLogicReset; tms=1 x4 must not reach it.
//   3 IDCODE read after reset:
//       - tms 0,1,0,0 to reach ShiftDr, then 32 edges with tms=0..0,1.
//       - tdo bits LSB first assemble to 32'h000FAF01; tdo_en high throughout.
//   4 IR scan loading 4'b1111 (tdi LSB first):
//       - bits shifted out on tdo = 1,0,0,0 (captured 01).
//       - After UpdateIr, ir_value=1111; a DR scan then echoes tdi delayed one edge, first tdo bit 0.
//   5 USER write with ir_value=1010, user_dr_in=8'h3C, shifting 8'hA5 in:
//       - tdo streams 0x3C LSB first.
//       - UpdateDr -> user_dr_out=8'hA5 and user_dr_update high exactly one cycle.
//   6 enable=0 for 3 edges mid-ShiftDr with tdi toggling -> state, chain and tdo unchanged.
//     Then trst=1 mid-scan -> ir_value=1110, state 0.

Source files
------------

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding and default instruction constants
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_t;

  localparam int          DEFAULT_IR_WIDTH      = 4;
  localparam int          DEFAULT_USER_DR_WIDTH = 8;
  localparam logic [31:0] DEFAULT_IDCODE        = 32'h000FAF01;
  localparam logic [3:0]  DEFAULT_INSTR_IDCODE  = 4'b1110;
  localparam logic [3:0]  DEFAULT_INSTR_USER    = 4'b1010;
  localparam logic [3:0]  DEFAULT_INSTR_BYPASS  = 4'b1111;

endpackage

// File: rtl/jtag_tap_param_if.sv
// rtl/jtag_tap_param_if.sv - JTAG pin and debug-side signal bundle
interface jtag_tap_param_if #(
  parameter int IR_WIDTH      = 4,
  parameter int USER_DR_WIDTH = 8
);
  import jtag_pkg::*;

  logic                     enable;
  logic                     tms;
  logic                     tdi;
  logic                     tdo;
  logic                     tdo_en;
  tap_state_t               tap_state;
  logic [IR_WIDTH-1:0]      ir_value;
  logic [USER_DR_WIDTH-1:0] user_dr_in;
  logic [USER_DR_WIDTH-1:0] user_dr_out;
  logic                     user_dr_update;

  // master drives the pins, slave is the TAP itself
  modport master (
    output enable, tms, tdi, user_dr_in,
    input  tdo, tdo_en, tap_state, ir_value, user_dr_out, user_dr_update
  );

  modport slave (
    input  enable, tms, tdi, user_dr_in,
    output tdo, tdo_en, tap_state, ir_value, user_dr_out, user_dr_update
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller driven by tms
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       enable,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t next_state
);

  // state register; enable=0 freezes the controller
  always_ff @(posedge tck) begin
    if (trst) begin
      state <= TEST_LOGIC_RESET;
    end else if (enable) begin
      state <= next_state;
    end
  end

  // standard TAP transition graph
  always_comb begin
    next_state = TEST_LOGIC_RESET;
    case (state)
      TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   next_state = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       next_state = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         next_state = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         next_state = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         next_state = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         next_state = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         next_state = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         next_state = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         next_state = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         next_state = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          next_state = TEST_LOGIC_RESET;
    endcase
  end

endmodule

// File: rtl/jtag_tap_param.sv
// rtl/jtag_tap_param.sv - parametrised TAP with IDCODE, BYPASS and USER data registers
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH      = DEFAULT_IR_WIDTH,
  parameter logic [31:0]         IDCODE_VALUE  = DEFAULT_IDCODE,
  parameter int                  USER_DR_WIDTH = DEFAULT_USER_DR_WIDTH,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE  = DEFAULT_INSTR_IDCODE,
  parameter logic [IR_WIDTH-1:0] INSTR_USER    = DEFAULT_INSTR_USER,
  parameter logic [IR_WIDTH-1:0] INSTR_BYPASS  = DEFAULT_INSTR_BYPASS
) (
  input  logic            tck,
  input  logic            trst,
  jtag_tap_param_if.slave bus
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_t               state;
  tap_state_t               next_state;
  logic [IR_WIDTH-1:0]      ir_chain;
  logic [IR_WIDTH-1:0]      ir_value;
  logic [31:0]              idcode_chain;
  logic                     bypass_reg;
  logic [USER_DR_WIDTH-1:0] user_chain;
  logic [USER_DR_WIDTH-1:0] user_shift;
  logic [USER_DR_WIDTH-1:0] user_dr_out;
  logic                     user_dr_update;
  logic                     sel_bypass;
  logic                     sel_idcode;
  logic                     sel_user;
  logic                     dr_bit;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .enable     (bus.enable),
    .tms        (bus.tms),
    .state      (state),
    .next_state (next_state)
  );

  // routing follows the updated instruction only; the bypass code wins any overlap
  assign sel_bypass = (ir_value == INSTR_BYPASS) ||
                      !((ir_value == INSTR_IDCODE) || (ir_value == INSTR_USER));
  assign sel_idcode = !sel_bypass && (ir_value == INSTR_IDCODE);
  assign sel_user   = !sel_bypass && !sel_idcode;

  // a one-bit USER chain has no upper slice to keep
  generate
    if (USER_DR_WIDTH == 1) begin : g_user_one
      assign user_shift = bus.tdi;
    end else begin : g_user_wide
      assign user_shift = {bus.tdi, user_chain[USER_DR_WIDTH-1:1]};
    end
  endgenerate

  // capture / shift / update of the IR and DR chains
  always_ff @(posedge tck) begin
    if (trst) begin
      ir_chain       <= '0;
      idcode_chain   <= '0;
      bypass_reg     <= 1'b0;
      user_chain     <= '0;
      ir_value       <= INSTR_IDCODE;
      user_dr_out    <= '0;
      user_dr_update <= 1'b0;
    end else if (!bus.enable) begin
      user_dr_update <= 1'b0;
    end else begin
      user_dr_update <= 1'b0;
      case (state)
        CAPTURE_IR: ir_chain <= IR_CAPTURE;
        SHIFT_IR:   ir_chain <= {bus.tdi, ir_chain[IR_WIDTH-1:1]};
        UPDATE_IR:  ir_value <= ir_chain;
        CAPTURE_DR: begin
          if (sel_idcode)    idcode_chain <= IDCODE_VALUE;
          else if (sel_user) user_chain   <= bus.user_dr_in;
          else               bypass_reg   <= 1'b0;
        end
        SHIFT_DR: begin
          if (sel_idcode)    idcode_chain <= {bus.tdi, idcode_chain[31:1]};
          else if (sel_user) user_chain   <= user_shift;
          else               bypass_reg   <= bus.tdi;
        end
        UPDATE_DR: begin
          if (sel_user) begin
            user_dr_out    <= user_chain;
            user_dr_update <= 1'b1;
          end
        end
        default: ;
      endcase
      if (next_state == TEST_LOGIC_RESET) begin
        ir_value <= INSTR_IDCODE;
      end
    end
  end

  // serial output: LSB of whichever chain is being shifted
  always_comb begin
    dr_bit = bypass_reg;
    if (sel_idcode)    dr_bit = idcode_chain[0];
    else if (sel_user) dr_bit = user_chain[0];
  end

  assign bus.tdo            = (state == SHIFT_IR) ? ir_chain[0] :
                              (state == SHIFT_DR) ? dr_bit : 1'b0;
  assign bus.tdo_en         = (state == SHIFT_IR) || (state == SHIFT_DR);
  assign bus.tap_state      = state;
  assign bus.ir_value       = ir_value;
  assign bus.user_dr_out    = user_dr_out;
  assign bus.user_dr_update = user_dr_update;

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb/tb_jtag_tap_param.sv - directed self-checking bench for jtag_tap_param
module tb_jtag_tap_param;
  import jtag_pkg::*;

  logic tck;
  logic trst;
  int   total_cnt;
  int   pass_cnt;

  jtag_tap_param_if #(.IR_WIDTH(4), .USER_DR_WIDTH(8)) bus ();

  jtag_tap_param dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic step(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] got;
    logic        en_all;
    logic [3:0]  ir_bits;
    logic [3:0]  tdi_pat;
    logic [7:0]  user_pat;

    total_cnt      = 0;
    pass_cnt       = 0;
    trst           = 1'b1;
    bus.enable     = 1'b1;
    bus.tms        = 1'b0;
    bus.tdi        = 1'b0;
    bus.user_dr_in = 8'h00;

    // 1: reset
    step(1'b0, 1'b0);
    chk("reset_state", 32'(bus.tap_state), 32'(TEST_LOGIC_RESET));
    chk("reset_ir", 32'(bus.ir_value), 32'h0000000E);
    chk("reset_tdo", 32'(bus.tdo), 32'd0);
    chk("reset_tdo_en", 32'(bus.tdo_en), 32'd0);
    chk("reset_user_out", 32'(bus.user_dr_out), 32'h00);
    trst = 1'b0;

    // 3: IDCODE read straight after reset
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("idc_in_shift", 32'(bus.tap_state), 32'(SHIFT_DR));
    got    = '0;
    en_all = 1'b1;
    for (int i = 0; i < 32; i++) begin
      got[i] = bus.tdo;
      en_all = en_all & bus.tdo_en;
      step(i == 31, 1'b0);
    end
    chk("idcode_value", got, 32'h000FAF01);
    chk("idcode_tdo_en", 32'(en_all), 32'd1);
    chk("idc_exit1", 32'(bus.tap_state), 32'(EXIT1_DR));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // 2: four tms=1 from ShiftDr stop short, the fifth reaches reset
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("tms1_x4", 32'(bus.tap_state), 32'(SELECT_IR_SCAN));
    step(1'b1, 1'b0);
    chk("tms1_x5", 32'(bus.tap_state), 32'(TEST_LOGIC_RESET));

    // 4: IR scan loading 1111
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("ir_tdo_en", 32'(bus.tdo_en), 32'd1);
    ir_bits = '0;
    for (int i = 0; i < 4; i++) begin
      ir_bits[i] = bus.tdo;
      step(i == 3, 1'b1);
    end
    chk("ir_capture_out", 32'(ir_bits), 32'h1);
    step(1'b1, 1'b0);
    chk("ir_before_update", 32'(bus.ir_value), 32'hE);
    step(1'b0, 1'b0);
    chk("ir_after_update", 32'(bus.ir_value), 32'hF);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tdi_pat = 4'b1101;
    ir_bits = '0;
    for (int i = 0; i < 4; i++) begin
      ir_bits[i] = bus.tdo;
      step(i == 3, tdi_pat[i]);
    end
    chk("bypass_echo", 32'(ir_bits), 32'hA);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // 5: USER write of A5 while capturing 3C
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tdi_pat = 4'b1010;
    for (int i = 0; i < 4; i++) step(i == 3, tdi_pat[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("ir_user", 32'(bus.ir_value), 32'hA);
    bus.user_dr_in = 8'h3C;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    user_pat = 8'hA5;
    got      = '0;
    for (int i = 0; i < 8; i++) begin
      got[i] = bus.tdo;
      step(i == 7, user_pat[i]);
    end
    chk("user_capture_out", got, 32'h3C);
    chk("user_out_pre", 32'(bus.user_dr_out), 32'h00);
    step(1'b1, 1'b0);
    chk("user_upd_pre", 32'(bus.user_dr_update), 32'd0);
    step(1'b0, 1'b0);
    chk("user_out", 32'(bus.user_dr_out), 32'hA5);
    chk("user_upd_pulse", 32'(bus.user_dr_update), 32'd1);
    step(1'b0, 1'b0);
    chk("user_upd_drop", 32'(bus.user_dr_update), 32'd0);

    // 6: hold with enable=0 mid-ShiftDr, then reset mid-scan
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("hold_pre_tdo", 32'(bus.tdo), 32'd1);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i[0]);
      chk("hold_state", 32'(bus.tap_state), 32'(SHIFT_DR));
      chk("hold_tdo", 32'(bus.tdo), 32'd1);
    end
    bus.enable = 1'b1;
    ir_bits = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      ir_bits[i] = bus.tdo;
    end
    chk("hold_resume", 32'(ir_bits), 32'h7);
    trst = 1'b1;
    step(1'b0, 1'b0);
    trst = 1'b0;
    chk("midscan_state", 32'(bus.tap_state), 32'(TEST_LOGIC_RESET));
    chk("midscan_ir", 32'(bus.ir_value), 32'hE);
    chk("midscan_tdo", 32'(bus.tdo), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
